// File: rtl/useq_pkg.sv
// Shared types for the parametrised Am2910-style sequencer: instruction
// encoding, decoded control bundle and the pure instruction decoder.
package useq_pkg;

  typedef enum logic [3:0] {
    JZ   = 4'd0,
    CJS  = 4'd1,
    JMAP = 4'd2,
    CJP  = 4'd3,
    PUSH = 4'd4,
    JSRP = 4'd5,
    CJV  = 4'd6,
    JRP  = 4'd7,
    RFCT = 4'd8,
    RPCT = 4'd9,
    CRTN = 4'd10,
    CJPP = 4'd11,
    LDCT = 4'd12,
    LOOP = 4'd13,
    CONT = 4'd14,
    TWB  = 4'd15
  } instr_e;

  typedef enum logic [2:0] {
    YSEL_ZERO,
    YSEL_D,
    YSEL_UPC,
    YSEL_R,
    YSEL_TOS
  } ysel_e;

  typedef struct packed {
    ysel_e ysel;
    logic  push;
    logic  pop;
    logic  load;
    logic  decr;
    logic  clear;
  } ctrl_t;

  // rnz is (R != 0); decr is only raised when the counter is non-zero.
  function automatic ctrl_t useq_decode(input instr_e instr, input logic fail,
                                        input logic rnz);
    ctrl_t c;
    logic  pass;
    pass    = ~fail;
    c.ysel  = YSEL_UPC;
    c.push  = 1'b0;
    c.pop   = 1'b0;
    c.load  = 1'b0;
    c.decr  = 1'b0;
    c.clear = 1'b0;
    case (instr)
      JZ: begin
        c.ysel  = YSEL_ZERO;
        c.clear = 1'b1;
      end
      CJS: begin
        c.ysel = pass ? YSEL_D : YSEL_UPC;
        c.push = pass;
      end
      JMAP: c.ysel = YSEL_D;
      CJP:  c.ysel = pass ? YSEL_D : YSEL_UPC;
      PUSH: begin
        c.push = 1'b1;
        c.load = pass;
      end
      JSRP: begin
        c.ysel = pass ? YSEL_D : YSEL_R;
        c.push = 1'b1;
      end
      CJV:  c.ysel = pass ? YSEL_D : YSEL_UPC;
      JRP:  c.ysel = pass ? YSEL_D : YSEL_R;
      RFCT: begin
        c.ysel = rnz ? YSEL_TOS : YSEL_UPC;
        c.decr = rnz;
        c.pop  = ~rnz;
      end
      RPCT: begin
        c.ysel = rnz ? YSEL_D : YSEL_UPC;
        c.decr = rnz;
      end
      CRTN: begin
        c.ysel = pass ? YSEL_TOS : YSEL_UPC;
        c.pop  = pass;
      end
      CJPP: begin
        c.ysel = pass ? YSEL_D : YSEL_UPC;
        c.pop  = pass;
      end
      LDCT: c.load = 1'b1;
      LOOP: begin
        c.ysel = pass ? YSEL_UPC : YSEL_TOS;
        c.pop  = pass;
      end
      CONT: c.ysel = YSEL_UPC;
      TWB: begin
        if (pass) begin
          c.ysel = YSEL_UPC;
          c.pop  = 1'b1;
        end else if (rnz) begin
          c.ysel = YSEL_TOS;
        end else begin
          c.ysel = YSEL_D;
          c.pop  = 1'b1;
        end
        c.decr = rnz;
      end
      default: c.ysel = YSEL_UPC;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/useq_stack.sv
// Subroutine/loop LIFO for the sequencer: storage, stack pointer, top-of-stack
// read and sticky overflow/underflow flags. Storage itself is never reset.
module useq_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           tos_o,
  output logic [$clog2(DEPTH+1)-1:0] sp_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       ovf_o,
  output logic                       unf_o
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SPW-1:0]   sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wrEn;
  logic [AW-1:0]    wrIdx;

  assign full_o  = (sp_q == SPW'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign sp_o    = sp_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;
  // Reading an empty stack yields zero so stale RAM contents never leak out.
  assign tos_o   = empty_o ? '0 : mem_q[AW'(sp_q - SPW'(1))];

  always_comb begin
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    wrEn  = 1'b0;
    wrIdx = full_o ? AW'(DEPTH - 1) : AW'(sp_q);
    if (clear_i) begin
      sp_d  = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (push_i) begin
      wrEn = 1'b1;
      if (full_o) ovf_d = 1'b1;
      else        sp_d  = sp_q + SPW'(1);
    end else if (pop_i) begin
      if (empty_o) unf_d = 1'b1;
      else         sp_d  = sp_q - SPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wrEn) mem_q[wrIdx] <= wdata_i;
  end

endmodule

// File: rtl/useq_2910p.sv
// Parametrised Am2910-style microprogram sequencer: uPC, loop counter R,
// next-address mux and source-enable decode around the subroutine stack.
module useq_2910p
  import useq_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3:0]                 I,
  input  logic                       CCEN_BAR,
  input  logic                       CC_BAR,
  input  logic                       RLD_BAR,
  input  logic                       CI,
  input  logic                       OEbar,
  input  logic [WIDTH-1:0]           D,
  output logic [WIDTH-1:0]           Y,
  output logic                       PL_BAR,
  output logic                       MAP_BAR,
  output logic                       VECT_BAR,
  output logic                       FULL_BAR,
  output logic                       EMPTY,
  output logic                       OVF,
  output logic                       UNF,
  output logic [$clog2(DEPTH+1)-1:0] SP_LEVEL
);

  logic [WIDTH-1:0] upc_q, upc_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] yInt;
  logic [WIDTH-1:0] tos;
  logic             fail;
  logic             rnz;
  logic             full;
  ctrl_t            ctrl;

  assign fail = CC_BAR & ~CCEN_BAR;
  assign rnz  = (r_q != '0);
  assign ctrl = useq_decode(instr_e'(I), fail, rnz);

  always_comb begin
    yInt = '0;
    case (ctrl.ysel)
      YSEL_D:   yInt = D;
      YSEL_UPC: yInt = upc_q;
      YSEL_R:   yInt = r_q;
      YSEL_TOS: yInt = tos;
      default:  yInt = '0;
    endcase
  end

  // OEbar only gates the pin; the incrementer always sees the internal address.
  assign Y        = OEbar ? '0 : yInt;
  assign MAP_BAR  = ~(I == 4'd2);
  assign VECT_BAR = ~(I == 4'd6);
  assign PL_BAR   = (I == 4'd2) | (I == 4'd6);
  assign FULL_BAR = ~full;

  always_comb begin
    upc_d = ctrl.clear ? '0 : yInt + {{(WIDTH-1){1'b0}}, CI};
    r_d   = r_q;
    if (!RLD_BAR || ctrl.load) r_d = D;
    else if (ctrl.decr && rnz) r_d = r_q - WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upc_q <= '0;
      r_q   <= '0;
    end else begin
      upc_q <= upc_d;
      r_q   <= r_d;
    end
  end

  useq_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_stack (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (ctrl.push),
    .pop_i  (ctrl.pop),
    .clear_i(ctrl.clear),
    .wdata_i(upc_q),
    .tos_o  (tos),
    .sp_o   (SP_LEVEL),
    .full_o (full),
    .empty_o(EMPTY),
    .ovf_o  (OVF),
    .unf_o  (UNF)
  );

endmodule

// File: tb/tb_useq_2910p.sv
// Self-checking bench for useq_2910p: directed vector table, hand-written
// stack/loop/wrap sequences and randomized traffic against a queue-based model.
module tb_useq_2910p;

  localparam int WIDTH = 12;
  localparam int DEPTH = 5;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst_n;
  logic [3:0]       I;
  logic             CCEN_BAR, CC_BAR, RLD_BAR, CI, OEbar;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Y;
  logic             PL_BAR, MAP_BAR, VECT_BAR, FULL_BAR, EMPTY, OVF, UNF;
  logic [2:0]       SP_LEVEL;

  int passCount  = 0;
  int checkCount = 0;

  // Reference model state: architectural registers plus a queue as the stack.
  int mUpc, mR;
  int mStk[$];
  bit mOvf, mUnf;
  int mY;
  bit mPush, mPop, mLoad, mDec, mClear;

  typedef struct {
    logic [3:0]       i;
    logic             ccenB, ccB, rldB, ci, oeB;
    logic [WIDTH-1:0] d;
    int               expY;
    int               expSp;
  } vec_t;

  vec_t vecs[7];

  useq_2910p #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .I(I), .CCEN_BAR(CCEN_BAR), .CC_BAR(CC_BAR),
    .RLD_BAR(RLD_BAR), .CI(CI), .OEbar(OEbar), .D(D), .Y(Y),
    .PL_BAR(PL_BAR), .MAP_BAR(MAP_BAR), .VECT_BAR(VECT_BAR),
    .FULL_BAR(FULL_BAR), .EMPTY(EMPTY), .OVF(OVF), .UNF(UNF),
    .SP_LEVEL(SP_LEVEL)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic modelEval();
    bit fail, pass, rnz;
    int tos;
    fail = CC_BAR && !CCEN_BAR;
    pass = !fail;
    rnz  = (mR != 0);
    tos  = (mStk.size() > 0) ? mStk[$] : 0;
    mY = mUpc; mPush = 0; mPop = 0; mLoad = 0; mDec = 0; mClear = 0;
    case (int'(I))
      0:  begin mY = 0; mClear = 1; end
      1:  if (pass) begin mY = D; mPush = 1; end
      2:  mY = D;
      3:  if (pass) mY = D;
      4:  begin mPush = 1; mLoad = pass; end
      5:  begin mPush = 1; mY = pass ? int'(D) : mR; end
      6:  if (pass) mY = D;
      7:  mY = pass ? int'(D) : mR;
      8:  if (rnz) begin mY = tos; mDec = 1; end else mPop = 1;
      9:  if (rnz) begin mY = D; mDec = 1; end
      10: if (pass) begin mY = tos; mPop = 1; end
      11: if (pass) begin mY = D; mPop = 1; end
      12: mLoad = 1;
      13: if (pass) mPop = 1; else mY = tos;
      14: mY = mUpc;
      default: begin
        if (pass) mPop = 1;
        else if (rnz) mY = tos;
        else begin mY = D; mPop = 1; end
        mDec = rnz;
      end
    endcase
  endtask

  task automatic modelCommit();
    if (!rst_n) begin
      mUpc = 0; mR = 0; mOvf = 0; mUnf = 0;
      mStk.delete();
    end else begin
      if (!RLD_BAR || mLoad) mR = int'(D);
      else if (mDec && mR > 0) mR = mR - 1;
      if (mPush) begin
        if (mStk.size() < DEPTH) mStk.push_back(mUpc);
        else begin mStk[DEPTH-1] = mUpc; mOvf = 1; end
      end
      if (mPop) begin
        if (mStk.size() > 0) void'(mStk.pop_back());
        else mUnf = 1;
      end
      if (mClear) begin
        mStk.delete(); mOvf = 0; mUnf = 0;
      end
      mUpc = (I == 4'd0) ? 0 : ((mY + int'(CI)) & MASK);
    end
  endtask

  // Drives one cycle's inputs and compares every output against the model.
  task automatic applyStimulus(input logic r, input logic [3:0] i, input logic ccenB,
                               input logic ccB, input logic rldB, input logic ci,
                               input logic oeB, input logic [WIDTH-1:0] d);
    rst_n = r; I = i; CCEN_BAR = ccenB; CC_BAR = ccB; RLD_BAR = rldB;
    CI = ci; OEbar = oeB; D = d;
    #2;
    modelEval();
    checkOutput("Y", int'(Y), OEbar ? 0 : mY);
    checkOutput("SP_LEVEL", int'(SP_LEVEL), mStk.size());
    checkOutput("EMPTY", int'(EMPTY), int'(mStk.size() == 0));
    checkOutput("FULL_BAR", int'(FULL_BAR), int'(mStk.size() != DEPTH));
    checkOutput("OVF", int'(OVF), int'(mOvf));
    checkOutput("UNF", int'(UNF), int'(mUnf));
    checkOutput("MAP_BAR", int'(MAP_BAR), int'(i != 4'd2));
    checkOutput("VECT_BAR", int'(VECT_BAR), int'(i != 4'd6));
    checkOutput("PL_BAR", int'(PL_BAR), int'(i == 4'd2 || i == 4'd6));
  endtask

  task automatic clockEdge();
    @(posedge clk);
    modelCommit();
    #1;
  endtask

  task automatic step(input logic [3:0] i, input logic ccenB, input logic ccB,
                      input logic ci, input logic oeB, input logic [WIDTH-1:0] d);
    applyStimulus(1'b1, i, ccenB, ccB, 1'b1, ci, oeB, d);
    clockEdge();
  endtask

  initial begin
    vecs[0] = '{4'd14, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 'h000, 0};
    vecs[1] = '{4'd14, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 'h001, 0};
    vecs[2] = '{4'd14, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 'h002, 0};
    vecs[3] = '{4'd3,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h010, 'h010, 0};
    vecs[4] = '{4'd1,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h200, 'h200, 0};
    vecs[5] = '{4'd10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 'h011, 1};
    vecs[6] = '{4'd14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 'h012, 0};

    rst_n = 1'b0; I = 4'd14; CCEN_BAR = 1'b1; CC_BAR = 1'b1; RLD_BAR = 1'b1;
    CI = 1'b0; OEbar = 1'b0; D = '0;
    mUpc = 0; mR = 0; mOvf = 0; mUnf = 0;
    @(posedge clk);
    modelCommit();
    #1;

    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, vecs[k].i, vecs[k].ccenB, vecs[k].ccB, vecs[k].rldB,
                    vecs[k].ci, vecs[k].oeB, vecs[k].d);
      checkOutput($sformatf("vecY[%0d]", k), int'(Y), vecs[k].expY);
      checkOutput($sformatf("vecSp[%0d]", k), int'(SP_LEVEL), vecs[k].expSp);
      checkOutput($sformatf("vecEmpty[%0d]", k), int'(EMPTY), int'(vecs[k].expSp == 0));
      clockEdge();
    end

    // Fill past capacity: six pushes of uPC values 0..5 into five entries.
    step(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 4'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
      if (k == 5) checkOutput("fullAfter5", int'(FULL_BAR), 0);
      clockEdge();
    end
    applyStimulus(1'b1, 4'd13, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    checkOutput("ovfSet", int'(OVF), 1);
    checkOutput("ovfSp", int'(SP_LEVEL), 5);
    checkOutput("ovfTop", int'(Y), 'h005);
    clockEdge();
    step(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    applyStimulus(1'b1, 4'd14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    checkOutput("jzOvf", int'(OVF), 0);
    checkOutput("jzSp", int'(SP_LEVEL), 0);
    clockEdge();

    applyStimulus(1'b1, 4'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    checkOutput("emptyTos", int'(Y), 0);
    clockEdge();
    applyStimulus(1'b1, 4'd14, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    checkOutput("unfSet", int'(UNF), 1);
    checkOutput("unfSp", int'(SP_LEVEL), 0);
    clockEdge();

    // Loop counter: return address 3, R=2 gives two TOS branches then fall-through.
    step(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    for (int k = 0; k < 3; k++) step(4'd14, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    step(4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
    step(4'd12, 1'b1, 1'b1, 1'b1, 1'b0, 12'h002);
    applyStimulus(1'b1, 4'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    checkOutput("rfct1", int'(Y), 'h003);
    clockEdge();
    applyStimulus(1'b1, 4'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    checkOutput("rfct2", int'(Y), 'h003);
    clockEdge();
    applyStimulus(1'b1, 4'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    checkOutput("rfct3", int'(Y), 'h004);
    clockEdge();
    applyStimulus(1'b1, 4'd14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    checkOutput("rfctPop", int'(SP_LEVEL), 0);
    checkOutput("rfctNext", int'(Y), 'h005);
    clockEdge();

    // Incrementer wrap, then OEbar hides Y while uPC keeps advancing.
    step(4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF);
    applyStimulus(1'b1, 4'd14, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    checkOutput("wrapTop", int'(Y), 'hFFF);
    clockEdge();
    applyStimulus(1'b1, 4'd14, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    checkOutput("wrapZero", int'(Y), 'h000);
    clockEdge();
    applyStimulus(1'b1, 4'd14, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000);
    checkOutput("oeGate", int'(Y), 0);
    clockEdge();
    applyStimulus(1'b1, 4'd14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    checkOutput("oeAdvance", int'(Y), 'h002);
    clockEdge();

    // Reset in the middle of a loop setup abandons stack and counter.
    step(4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
    step(4'd12, 1'b1, 1'b1, 1'b1, 1'b0, 12'h005);
    applyStimulus(1'b0, 4'd14, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    clockEdge();
    applyStimulus(1'b1, 4'd14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    checkOutput("rstY", int'(Y), 0);
    checkOutput("rstEmpty", int'(EMPTY), 1);
    checkOutput("rstFull", int'(FULL_BAR), 1);
    clockEdge();

    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 49) != 0), 4'($urandom_range(0, 15)),
                    1'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0),
                    1'($urandom), ($urandom_range(0, 7) == 0), 12'($urandom));
      clockEdge();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
